// File: rtl/tim_apb_master.sv
// ---------------------------------------------------------------------------
// tim_apb_master
//
// Purpose:
//   Converts a simple valid/ready command stream into single APB transfers
//   (IDLE -> SETUP -> ACCESS) and returns one response per command on a
//   valid/ready response channel. Reads return prdata; writes return 0.
//   rsp_err reports pslverr (or an ACCESS timeout when that option is built).
//
// Ports:
//   pclk, presetn            clock, synchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_prot      command payload
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       response payload
//   psel, penable, pwrite,
//   paddr, pwdata, pprot     APB request (all registered)
//   prdata, pready, pslverr  APB completion
//
// Parameter:
//   TIMEOUT_CYCLES           ACCESS wait cycles tolerated before abort (1..65535)
//
// Build option:
//   TIM_APB_MASTER_TIMEOUT_EN  when defined, an ACCESS phase that sees
//                              TIMEOUT_CYCLES wait states and still no pready
//                              is ended with rsp_err=1, rsp_rdata=0.
//                              When undefined, ACCESS waits forever.
// ---------------------------------------------------------------------------
module tim_apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [2:0]  cmd_prot,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic [2:0]  pprot,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;

    // Catch out-of-range configuration at elaboration time.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("tim_apb_master: TIMEOUT_CYCLES must be in 1..65535");
    end

`ifdef TIM_APB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_cnt;
`endif

    // A new command is only taken when the response slot is free or is being
    // drained this very edge, so a pending response can never be overwritten.
    assign cmd_ready = (state == IDLE) & (~rsp_valid | rsp_ready) & presetn;

    // Single FSM block: all APB and response outputs are registered here.
    // The response clear is written first so that a load in the same edge wins.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= 32'd0;
            pwdata    <= 32'd0;
            pprot     <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
`ifdef TIM_APB_MASTER_TIMEOUT_EN
            wait_cnt  <= 16'd0;
`endif
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_write ? cmd_wdata : 32'd0;
                        pwrite  <= cmd_write;
                        pprot   <= cmd_prot;
                        psel    <= 1'b1;
                        penable <= 1'b0;
`ifdef TIM_APB_MASTER_TIMEOUT_EN
                        wait_cnt <= 16'd0;
`endif
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (pready) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pwrite ? 32'd0 : prdata;
                        rsp_err   <= pslverr;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef TIM_APB_MASTER_TIMEOUT_EN
                    // Counter already holds the number of elapsed wait states.
                    else if (wait_cnt == TIMEOUT_LIMIT) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b1;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end

                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tim_apb_master.sv
// ---------------------------------------------------------------------------
// tb_tim_apb_master
//
// Self-checking bench for tim_apb_master. A fixed vector table and a set of
// randomized transfers are each run through one transfer task whose expected
// cycle timing and response values come straight from the protocol rules
// (SETUP one cycle after acceptance, ACCESS for waits+1 cycles, response the
// cycle after). Hand-written sequences cover back-to-back streaming, reset
// during ACCESS and the ACCESS timeout option (TIM_APB_MASTER_TIMEOUT_EN).
// ---------------------------------------------------------------------------
module tb_tim_apb_master;

    localparam int TIMEOUT = 8;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  prot;
        int          waits;
        logic        stuck;
        logic [31:0] rd;
        logic        slv;
        int          hold;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t vecs[4];

    tim_apb_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_prot  (cmd_prot),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pprot     (pprot),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    // Free-running clock.
    always #5 pclk = ~pclk;

    // Hard stop in case something leaves the bench waiting forever.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic stepClk();
        @(posedge pclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // One complete command/response exchange. Called in IDLE with no pending
    // response, just after a rising edge; returns in the same condition.
    task automatic applyStimulus(input vec_t v);
        logic [31:0] expWdata;
        expWdata  = v.wr ? v.wdata : 32'd0;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_prot  = v.prot;
        rsp_ready = 1'b1;
        pready    = 1'b0;
        #1;
        checkOutput("cmdReadyIdle", cmd_ready, 1'b1);
        stepClk();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        prdata    = $urandom;
        pslverr   = 1'($urandom_range(0, 1));
        checkOutput("setupPsel", psel, 1'b1);
        checkOutput("setupPenable", penable, 1'b0);
        checkOutput("setupPaddr", paddr, v.addr);
        checkOutput("setupPwrite", pwrite, v.wr);
        checkOutput("setupPprot", pprot, v.prot);
        checkOutput("setupPwdata", pwdata, expWdata);
        stepClk();
        for (int i = 0; i <= v.waits; i++) begin
            pready  = !v.stuck && (i == v.waits);
            prdata  = pready ? v.rd : $urandom;
            pslverr = pready ? v.slv : 1'($urandom_range(0, 1));
            checkOutput("accessPsel", psel, 1'b1);
            checkOutput("accessPenable", penable, 1'b1);
            checkOutput("accessPaddr", paddr, v.addr);
            checkOutput("accessPwdata", pwdata, expWdata);
            checkOutput("accessRspValid", rsp_valid, 1'b0);
            stepClk();
        end
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'b1;
        checkOutput("rspValid", rsp_valid, 1'b1);
        checkOutput("rspRdata", rsp_rdata, v.expRdata);
        checkOutput("rspErr", rsp_err, v.expErr);
        checkOutput("rspPsel", psel, 1'b0);
        checkOutput("rspPenable", penable, 1'b0);
        for (int h = 0; h < v.hold; h++) begin
            cmd_valid = 1'b1;
            rsp_ready = 1'b0;
            #1;
            checkOutput("holdCmdReady", cmd_ready, 1'b0);
            checkOutput("holdRspValid", rsp_valid, 1'b1);
            checkOutput("holdRspRdata", rsp_rdata, v.expRdata);
            checkOutput("holdRspErr", rsp_err, v.expErr);
            checkOutput("holdPsel", psel, 1'b0);
            stepClk();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        checkOutput("preDrainRspValid", rsp_valid, 1'b1);
        stepClk();
        checkOutput("drainRspValid", rsp_valid, 1'b0);
        checkOutput("drainPsel", psel, 1'b0);
    endtask

    initial begin
        vec_t        r;
        logic [31:0] b2bAddr[3];
        logic [31:0] b2bData[3];
        int          held;

        presetn   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'hFFFF_FFFF;
        cmd_prot  = 3'h7;
        rsp_ready = 1'b0;
        prdata    = 32'h1234_5678;
        pready    = 1'b1;
        pslverr   = 1'b1;

        // Reset state, with a command offered the whole time.
        repeat (3) stepClk();
        checkOutput("rstCmdReady", cmd_ready, 1'b0);
        checkOutput("rstPsel", psel, 1'b0);
        checkOutput("rstPenable", penable, 1'b0);
        checkOutput("rstPwrite", pwrite, 1'b0);
        checkOutput("rstPaddr", paddr, 32'd0);
        checkOutput("rstPwdata", pwdata, 32'd0);
        checkOutput("rstPprot", pprot, 3'd0);
        checkOutput("rstRspValid", rsp_valid, 1'b0);
        checkOutput("rstRspRdata", rsp_rdata, 32'd0);
        checkOutput("rstRspErr", rsp_err, 1'b0);
        presetn = 1'b1;
        cmd_valid = 1'b0;
        pready = 1'b0;
        #1;
        checkOutput("firstCycleCmdReady", cmd_ready, 1'b1);
        stepClk();

        // Directed vectors: zero-wait write, 4-wait read, slave error read
        // with a stalled response, protected write with wait states.
        vecs[0] = '{1'b1, 32'h4001_1000, 32'h0000_00FF, 3'd0, 0, 1'b0,
                    32'hAAAA_5555, 1'b0, 0, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h4001_1004, 32'h5A5A_5A5A, 3'd2, 4, 1'b0,
                    32'hDEAD_BEEF, 1'b0, 0, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b0, 32'h4001_1008, 32'h0000_0000, 3'd1, 1, 1'b0,
                    32'h0BAD_F00D, 1'b1, 5, 32'h0BAD_F00D, 1'b1};
        vecs[3] = '{1'b1, 32'h8000_0010, 32'hCAFE_0001, 3'd7, 2, 1'b0,
                    32'h7777_7777, 1'b1, 2, 32'h0000_0000, 1'b1};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
        end

        // Randomized transfers; expected response from the read/write rule.
        for (int i = 0; i < 20; i++) begin
            r.wr       = 1'($urandom_range(0, 1));
            r.addr     = $urandom;
            r.wdata    = $urandom;
            r.prot     = 3'($urandom_range(0, 7));
            r.waits    = $urandom_range(0, 5);
            r.stuck    = 1'b0;
            r.rd       = $urandom;
            r.slv      = 1'($urandom_range(0, 1));
            r.hold     = $urandom_range(0, 3);
            r.expRdata = r.wr ? 32'd0 : r.rd;
            r.expErr   = r.slv;
            applyStimulus(r);
        end

        // Back-to-back writes: acceptance every third cycle.
        b2bAddr[0] = 32'h1000_0000; b2bData[0] = 32'h0000_0011;
        b2bAddr[1] = 32'h1000_0004; b2bData[1] = 32'h0000_0022;
        b2bAddr[2] = 32'h1000_0008; b2bData[2] = 32'h0000_0033;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_prot  = 3'd0;
        rsp_ready = 1'b1;
        pready    = 1'b1;
        pslverr   = 1'b0;
        for (int c = 0; c < 9; c++) begin
            cmd_addr  = b2bAddr[c / 3];
            cmd_wdata = b2bData[c / 3];
            #1;
            if (c % 3 == 0) begin
                checkOutput("b2bCmdReady", cmd_ready, 1'b1);
                checkOutput("b2bRspValid", rsp_valid, (c > 0) ? 1'b1 : 1'b0);
            end else if (c % 3 == 1) begin
                checkOutput("b2bSetupCmdReady", cmd_ready, 1'b0);
                checkOutput("b2bSetupPsel", psel, 1'b1);
                checkOutput("b2bSetupPenable", penable, 1'b0);
                checkOutput("b2bSetupPaddr", paddr, b2bAddr[c / 3]);
                checkOutput("b2bSetupPwdata", pwdata, b2bData[c / 3]);
            end else begin
                checkOutput("b2bAccessPenable", penable, 1'b1);
            end
            stepClk();
        end
        cmd_valid = 1'b0;
        pready    = 1'b0;
        checkOutput("b2bLastRspValid", rsp_valid, 1'b1);
        checkOutput("b2bLastRspRdata", rsp_rdata, 32'd0);
        stepClk();
        checkOutput("b2bDrained", rsp_valid, 1'b0);

        // Reset during ACCESS: transfer abandoned, no response afterwards.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h2000_0000;
        pready    = 1'b0;
        stepClk();
        cmd_valid = 1'b0;
        stepClk();
        checkOutput("preRstPenable", penable, 1'b1);
        presetn = 1'b0;
        #1;
        checkOutput("inRstCmdReady", cmd_ready, 1'b0);
        stepClk();
        checkOutput("abortPsel", psel, 1'b0);
        checkOutput("abortPenable", penable, 1'b0);
        checkOutput("abortRspValid", rsp_valid, 1'b0);
        checkOutput("abortPaddr", paddr, 32'd0);
        presetn = 1'b1;
        pready  = 1'b1;
        prdata  = 32'hFEED_FACE;
        for (int i = 0; i < 4; i++) begin
            stepClk();
            checkOutput("postAbortRspValid", rsp_valid, 1'b0);
            checkOutput("postAbortPsel", psel, 1'b0);
        end
        pready = 1'b0;

`ifdef TIM_APB_MASTER_TIMEOUT_EN
        // Stuck slave: ends after TIMEOUT wait states with an error response.
        r = '{1'b0, 32'h3000_0000, 32'd0, 3'd0, TIMEOUT, 1'b1,
              32'h1111_2222, 1'b0, 1, 32'h0000_0000, 1'b1};
        applyStimulus(r);
`else
        // Stuck slave without the timeout option: ACCESS is held indefinitely.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h3000_0000;
        stepClk();
        cmd_valid = 1'b0;
        stepClk();
        held = 0;
        for (int i = 0; i < 1000; i++) begin
            stepClk();
            if (psel && penable && !rsp_valid) held++;
        end
        checkOutput("noTimeoutHeld", held, 1000);
        presetn = 1'b0;
        stepClk();
        presetn = 1'b1;
        checkOutput("noTimeoutRecover", psel, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
